// File: rtl/demux2_stream.sv
// Two-output val/rdy stream demultiplexor with a one-entry buffer and
// per-output transfer counters.
module demux2_stream #(
  parameter int unsigned nbits = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_msg,
  input  logic             in_sel,
  output logic             out0_val,
  input  logic             out0_rdy,
  output logic [nbits-1:0] out0_msg,
  output logic             out1_val,
  input  logic             out1_rdy,
  output logic [nbits-1:0] out1_msg,
  output logic [7:0]       count0,
  output logic [7:0]       count1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [nbits-1:0] r_buf_msg;
  logic             r_buf_sel;
  logic [7:0]       r_count0;
  logic [7:0]       r_count1;

  logic w_deq0;
  logic w_deq1;
  logic w_deq;
  logic w_enq;

  always_comb begin
    out0_val = (r_state == FULL) && !r_buf_sel;
    out1_val = (r_state == FULL) &&  r_buf_sel;
    out0_msg = out0_val ? r_buf_msg : '0;
    out1_msg = out1_val ? r_buf_msg : '0;
    w_deq0   = out0_val && out0_rdy;
    w_deq1   = out1_val && out1_rdy;
    w_deq    = w_deq0 || w_deq1;
    // Ready looks through the consumer's rdy so a full buffer can drain and refill in one cycle.
    in_rdy   = (r_state == EMPTY) || w_deq;
    w_enq    = in_val && in_rdy;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_enq) w_state_nxt = FULL;
      FULL:  if (w_deq && !w_enq) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_buf_msg <= '0;
      r_buf_sel <= 1'b0;
      r_count0  <= '0;
      r_count1  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enq) begin
        r_buf_msg <= in_msg;
        r_buf_sel <= in_sel;
      end
      if (w_deq0) r_count0 <= r_count0 + 8'd1;
      if (w_deq1) r_count1 <= r_count1 + 8'd1;
    end
  end

  assign count0 = r_count0;
  assign count1 = r_count1;

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_demux2_stream;
  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_val = 1'b0;
  logic          in_sel = 1'b0;
  logic [NB-1:0] in_msg = '0;
  logic          out0_rdy = 1'b0;
  logic          out1_rdy = 1'b0;
  logic          in_rdy;
  logic          out0_val;
  logic          out1_val;
  logic [NB-1:0] out0_msg;
  logic [NB-1:0] out1_msg;
  logic [7:0]    count0;
  logic [7:0]    count1;

  demux2_stream #(.nbits(NB)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_sel(in_sel),
    .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_msg(out0_msg),
    .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_msg(out1_msg),
    .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: at most one pending {sel,msg}, plus transfer counts.
  logic [NB:0] mq[$];
  int          m_c0 = 0;
  int          m_c1 = 0;
  bit          started = 1'b0;

  logic [NB:0] xlog[$];
  int          xcyc[$];
  int          cyc = 0;
  bit          seen_f = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit d;
    bit r;
    cyc++;
    if (rst) begin
      mq.delete();
      m_c0 = 0;
      m_c1 = 0;
      started = 1'b1;
    end else if (started) begin
      d = (mq.size() != 0) && (mq[0][NB] ? out1_rdy : out0_rdy);
      r = (mq.size() == 0) || d;
      if (d) begin
        if (mq[0][NB]) m_c1 = (m_c1 + 1) % 256;
        else           m_c0 = (m_c0 + 1) % 256;
        void'(mq.pop_front());
      end
      if (in_val && r) mq.push_back({in_sel, in_msg});
    end
  end

  always @(negedge clk) begin
    logic          ev0;
    logic          ev1;
    logic          erdy;
    logic [NB-1:0] em;
    if (started) begin
      ev0  = (mq.size() != 0) && !mq[0][NB];
      ev1  = (mq.size() != 0) &&  mq[0][NB];
      em   = (mq.size() != 0) ? mq[0][NB-1:0] : '0;
      erdy = (mq.size() == 0) || (ev0 && out0_rdy) || (ev1 && out1_rdy);
      chk("out0_val", 32'(out0_val), 32'(ev0));
      chk("out1_val", 32'(out1_val), 32'(ev1));
      chk("out0_msg", 32'(out0_msg), ev0 ? 32'(em) : 32'd0);
      chk("out1_msg", 32'(out1_msg), ev1 ? 32'(em) : 32'd0);
      chk("in_rdy",   32'(in_rdy),   32'(erdy));
      chk("count0",   32'(count0),   32'(m_c0));
      chk("count1",   32'(count1),   32'(m_c1));
      if (out1_val && out1_msg == 4'hF) seen_f = 1'b1;
      if (!rst && out0_val && out0_rdy) begin xlog.push_back({1'b0, out0_msg}); xcyc.push_back(cyc); end
      if (!rst && out1_val && out1_rdy) begin xlog.push_back({1'b1, out1_msg}); xcyc.push_back(cyc); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_val = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [NB:0] e;

    // Reset then idle
    do_reset(2);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_vals", 32'({out0_val, out1_val}), 32'd0);
    chk("rst_msgs", 32'({out0_msg, out1_msg}), 32'd0);
    chk("rst_counts", 32'({count0, count1}), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("idle_in_rdy", 32'(in_rdy), 32'd1);
    chk("idle_state", 32'({out0_val, out1_val, out0_msg, out1_msg, count0, count1}), 32'd0);

    // Single routed message
    in_val = 1'b1; in_msg = 4'hA; in_sel = 1'b1; out1_rdy = 1'b1;
    tick();
    in_val = 1'b0; in_msg = 4'h3;
    chk("single_out1_val", 32'(out1_val), 32'd1);
    chk("single_out1_msg", 32'(out1_msg), 32'hA);
    chk("single_out0", 32'({out0_val, out0_msg}), 32'd0);
    tick();
    chk("single_count1", 32'(count1), 32'd1);
    chk("single_empty", 32'({out0_val, out1_val, in_rdy}), 32'b001);

    // Backpressure
    out0_rdy = 1'b0; out1_rdy = 1'b1;
    in_val = 1'b1; in_msg = 4'h5; in_sel = 1'b0;
    tick();
    in_msg = 4'h9; in_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out0_val", 32'(out0_val), 32'd1);
      chk("bp_out0_msg", 32'(out0_msg), 32'h5);
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
      tick();
    end
    in_val = 1'b0;
    out0_rdy = 1'b1;
    #1;
    chk("bp_release_in_rdy", 32'(in_rdy), 32'd1);
    tick();
    chk("bp_count0", 32'(count0), 32'd1);
    chk("bp_second_dropped", 32'({out0_val, out1_val, count1}), 32'd1);

    // Full throughput, alternating destinations
    do_reset(1);
    out0_rdy = 1'b1; out1_rdy = 1'b1;
    xlog.delete(); xcyc.delete();
    for (int i = 1; i <= 8; i++) begin
      in_val = 1'b1; in_msg = NB'(i); in_sel = ((i - 1) % 2 == 1);
      tick();
    end
    in_val = 1'b0;
    tick();
    tick();
    chk("tp_n_xfers", 32'(xlog.size()), 32'd8);
    if (xlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        e = {1'b0, NB'(i + 1)};
        e[NB] = (i % 2 == 1);
        chk("tp_order", 32'(xlog[i]), 32'(e));
      end
      chk("tp_consecutive", 32'(xcyc[7] - xcyc[0]), 32'd7);
    end
    chk("tp_count0", 32'(count0), 32'd4);
    chk("tp_count1", 32'(count1), 32'd4);

    // Counter wrap
    do_reset(1);
    out0_rdy = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_val = 1'b1; in_sel = 1'b0; in_msg = NB'($urandom);
      tick();
    end
    in_val = 1'b0;
    tick();
    chk("wrap_count0", 32'(count0), 32'd1);
    chk("wrap_count1", 32'(count1), 32'd0);

    // Reset mid-operation
    out1_rdy = 1'b0;
    in_val = 1'b1; in_msg = 4'hF; in_sel = 1'b1;
    tick();
    in_val = 1'b0;
    chk("mid_pending", 32'({out1_val, out1_msg}), 32'h1F);
    do_reset(1);
    seen_f = 1'b0;
    chk("mid_out1_val", 32'(out1_val), 32'd0);
    chk("mid_out1_msg", 32'(out1_msg), 32'd0);
    chk("mid_count1", 32'(count1), 32'd0);
    out1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_f_never_seen", 32'(seen_f), 32'd0);

    // Randomized traffic with occasional resets, checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_val   = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom);
      in_msg   = NB'($urandom);
      out0_rdy = ($urandom_range(0, 9) < 7);
      out1_rdy = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0;
    in_val = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
